// File: rtl/counter7sd_pkg.sv
// Shared definitions for the Counter7SD control sequencer: FSM encoding and default tuning constants.
package counter7sd_pkg;

    localparam int unsigned STATE_W          = 2;
    localparam int unsigned DEBOUNCE_CYC_DEF = 4;
    localparam int unsigned PRESCALE_DEF     = 10;
    localparam int unsigned AUTO_STEPS_DEF   = 12;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        AUTO = 2'd3
    } state_e;

endpackage

// File: rtl/counter7sd_ctrl_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter, and a one-cycle pulse on an accepted press.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_press;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_stable_nxt;
    logic             w_press_nxt;

    // Stable level flips on the DEBOUNCE_CYC-th consecutive differing sample; only rises emit a press.
    always_comb begin
        w_cnt_nxt    = '0;
        w_stable_nxt = r_stable;
        w_press_nxt  = 1'b0;
        if (r_sync[1] != r_stable) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                w_stable_nxt = r_sync[1];
                w_press_nxt  = r_sync[1];
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_btn};
            r_cnt    <= w_cnt_nxt;
            r_stable <= w_stable_nxt;
            r_press  <= w_press_nxt;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/counter7sd_ctrl.sv
// Mode sequencer for Counter7SD: debounced pause/reverse toggles, prescaled count tick and a self-running demo mode.
module counter7sd_ctrl
    import counter7sd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned PRESCALE     = PRESCALE_DEF,
    parameter int unsigned AUTO_STEPS   = AUTO_STEPS_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               btn_pause,
    input  logic               btn_reverse,
    input  logic               auto_en,
    output logic               pause,
    output logic               reverse,
    output logic               tick,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned PRE_W  = $clog2(PRESCALE);
    localparam int unsigned STEP_W = $clog2(AUTO_STEPS + 1);

    state_e            r_state;
    logic [PRE_W-1:0]  r_pre;
    logic [STEP_W-1:0] r_step;
    logic              r_pause;
    logic              r_reverse;
    logic              r_tick;

    state_e            w_state_nxt;
    logic [PRE_W-1:0]  w_pre_nxt;
    logic [STEP_W-1:0] w_step_nxt;
    logic              w_pause_nxt;
    logic              w_reverse_nxt;
    logic              w_tick_nxt;
    logic              w_pause_ev;
    logic              w_reverse_ev;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_pause (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (btn_pause),
        .o_press (w_pause_ev)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_reverse (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (btn_reverse),
        .o_press (w_reverse_ev)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pre     <= '0;
            r_step    <= '0;
            r_pause   <= 1'b1;
            r_reverse <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre     <= w_pre_nxt;
            r_step    <= w_step_nxt;
            r_pause   <= w_pause_nxt;
            r_reverse <= w_reverse_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pre_nxt     = r_pre;
        w_step_nxt    = r_step;
        w_reverse_nxt = r_reverse;
        w_tick_nxt    = 1'b0;

        // auto_en outranks any same-cycle button event; in AUTO the buttons are ignored.
        case (r_state)
            IDLE, RUN, HOLD: begin
                if (auto_en) begin
                    w_state_nxt = AUTO;
                end else begin
                    if (w_pause_ev) begin
                        if (r_state == RUN) w_state_nxt = HOLD;
                        else                w_state_nxt = RUN;
                    end
                    if (w_reverse_ev) w_reverse_nxt = ~r_reverse;
                end
            end
            AUTO: begin
                if (!auto_en) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        // Prescaler only advances on edges that stay in RUN/AUTO, so a leaving edge never ticks or loses count.
        if ((w_state_nxt == IDLE) || ((w_state_nxt == AUTO) && (r_state != AUTO))) begin
            w_pre_nxt  = '0;
            w_step_nxt = '0;
        end else if (((r_state == RUN) || (r_state == AUTO)) && (w_state_nxt == r_state)) begin
            if (r_pre == PRE_W'(PRESCALE - 1)) begin
                w_pre_nxt  = '0;
                w_tick_nxt = 1'b1;
                if (r_state == AUTO) begin
                    if (r_step == STEP_W'(AUTO_STEPS - 1)) begin
                        w_step_nxt    = '0;
                        w_reverse_nxt = ~r_reverse;
                    end else begin
                        w_step_nxt = r_step + STEP_W'(1);
                    end
                end
            end else begin
                w_pre_nxt = r_pre + PRE_W'(1);
            end
        end

        w_pause_nxt = (w_state_nxt == IDLE) || (w_state_nxt == HOLD);
    end

    assign pause   = r_pause;
    assign reverse = r_reverse;
    assign tick    = r_tick;
    assign state   = r_state;

endmodule
